// File: rtl/imem_loader.sv
// Loads the instruction bank from a byte stream: four bytes form one big-endian word, and each word is written to the next address.
// The CPU is held until every requested word has been written.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_CPU,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [ADDR_WIDTH:0]   CAP    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_1  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_1 = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]   wr_q, wr_d;
   logic [1:0]            bidx_q, bidx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [ADDR_WIDTH:0]   wr_inc;

   assign wr_inc = wr_q + CNT_1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      bidx_d  = bidx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_COLLECT;
                  cnt_d   = (word_count > CAP) ? CAP : word_count;
                  wr_d    = '0;
                  addr_d  = '0;
                  bidx_d  = '0;
               end
            end
         end
         S_COLLECT: begin
            // byte_ready is high throughout this state, so byte_valid alone marks a handshake
            if (byte_valid) begin
               wdata_d = {wdata_q[23:0], byte_in};
               bidx_d  = bidx_q + 2'd1;
               if (bidx_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_d   = wr_inc;
            addr_d = addr_q + ADDR_1;
            bidx_d = '0;
            state_d = (wr_inc == cnt_q) ? S_DONE : S_COLLECT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_CPU or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= '0;
         bidx_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         bidx_q  <= bidx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Outputs are decoded from registered state only
   assign byte_ready = (state_q == S_COLLECT);
   assign mem_we     = (state_q == S_WRITE);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_hold   = (state_q != S_DONE);
   assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table-driven cycle trace plus sequences for stalls, reset and clamping.
// Instance a uses ADDR_WIDTH=8 and instance b uses ADDR_WIDTH=2 for the wrap/clamp case.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic [8:0] wc_a = '0;
   logic [2:0] wc_b = '0;
   logic [7:0] byte_in = '0;
   logic byte_valid = 1'b0;

   logic br_a, we_a, hold_a, busy_a, done_a;
   logic [7:0] addr_a;
   logic [31:0] wd_a;
   logic br_b, we_b, hold_b, busy_b, done_b;
   logic [1:0] addr_b;
   logic [31:0] wd_b;

   int sel = 0;
   int ncmp = 0, nfail = 0;
   logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
   logic [31:0] ea[$], ed[$];
   logic [7:0] bq[$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(8)) dut_a (
      .clk_CPU(clk), .rst(rst), .start(start_a), .word_count(wc_a),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br_a),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .cpu_hold(hold_a), .busy(busy_a), .done(done_a));

   imem_loader #(.ADDR_WIDTH(2)) dut_b (
      .clk_CPU(clk), .rst(rst), .start(start_b), .word_count(wc_b),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br_b),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .cpu_hold(hold_b), .busy(busy_b), .done(done_b));

   logic m_br, m_we, m_hold, m_busy, m_done;
   logic [31:0] m_addr, m_wd;
   assign m_br   = (sel != 0) ? br_b   : br_a;
   assign m_we   = (sel != 0) ? we_b   : we_a;
   assign m_hold = (sel != 0) ? hold_b : hold_a;
   assign m_busy = (sel != 0) ? busy_b : busy_a;
   assign m_done = (sel != 0) ? done_b : done_a;
   assign m_addr = (sel != 0) ? 32'(addr_b) : 32'(addr_a);
   assign m_wd   = (sel != 0) ? wd_b : wd_a;

   // write log, sampled with the pre-edge value of each registered output
   always @(posedge clk) begin
      if (we_a) begin qa_addr.push_back(32'(addr_a)); qa_data.push_back(wd_a); end
      if (we_b) begin qb_addr.push_back(32'(addr_b)); qb_data.push_back(wd_b); end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_writes(input int s, input string nm);
      int n;
      n = (s != 0) ? qb_addr.size() : qa_addr.size();
      chk({nm, "_nwr"}, n, ea.size());
      for (int i = 0; i < n && i < ea.size(); i++) begin
         chk({nm, "_waddr"}, (s != 0) ? qb_addr[i] : qa_addr[i], ea[i]);
         chk({nm, "_wdata"}, (s != 0) ? qb_data[i] : qa_data[i], ed[i]);
      end
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
      ea.delete(); ed.delete();
   endtask

   // Called at a negedge. Pulses start, then streams bq until done or stop_after bytes accepted.
   task automatic do_load(input int s, input int wc, input bit stall, input int stop_after,
                          output int cyc);
      int idx;
      bit tog, present;
      sel = s;
      if (s != 0) begin start_b = 1'b1; wc_b = 3'(wc); end
      else begin start_a = 1'b1; wc_a = 9'(wc); end
      byte_valid = 1'b0;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      chk("start_collect_br", m_br, 1'b1);
      chk("start_hold", m_hold, 1'b1);
      chk("start_done", m_done, 1'b0);
      idx = 0; tog = 1'b0; cyc = 0;
      forever begin
         if (m_done || idx >= stop_after) break;
         if (cyc > 200) begin
            ncmp++; nfail++;
            $display("FAIL load_timeout: got no done after %0d cycles, expected done", cyc);
            break;
         end
         present = (idx < bq.size()) && (!stall || tog);
         byte_valid = present;
         byte_in = present ? bq[idx] : 8'h00;
         if (present && m_br) idx++;
         if (m_br) tog = !tog;
         @(negedge clk);
         cyc++;
      end
      byte_valid = 1'b0;
   endtask

   typedef struct {
      logic st; logic [8:0] wc; logic bv; logic [7:0] b;
      logic br; logic we; logic [7:0] addr; logic [31:0] wd;
      logic hold; logic busy; logic done;
   } vec_t;
   vec_t tbl[12];

   initial begin
      int cyc;
      //         st    wc    bv    byte   | br    we    addr  wdata          hold  busy  done
      tbl[0]  = '{1'b1, 9'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 9'd9, 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 9'd7, 1'b1, 8'h08, 1'b1, 1'b0, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 9'd2, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 9'd2, 1'b1, 8'h05, 1'b0, 1'b1, 8'd0, 32'h20080005,  1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 9'd2, 1'b1, 8'h01, 1'b1, 1'b0, 8'd1, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 9'd2, 1'b1, 8'h01, 1'b1, 1'b0, 8'd1, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 9'd2, 1'b1, 8'h09, 1'b1, 1'b0, 8'd1, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 9'd2, 1'b1, 8'h50, 1'b1, 1'b0, 8'd1, 32'h0,         1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 9'd2, 1'b1, 8'h20, 1'b0, 1'b1, 8'd1, 32'h01095020,  1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 9'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2, 32'h0,         1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 9'd2, 1'b1, 8'hAA, 1'b0, 1'b0, 8'd2, 32'h0,         1'b0, 1'b0, 1'b1};

      // reset values, then 10 idle cycles
      repeat (3) @(negedge clk);
      chk("rst_hold", hold_a, 1'b1);
      chk("rst_addr", 32'(addr_a), 32'd0);
      chk("rst_wdata", wd_a, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_hold", hold_a, 1'b1);
         chk("idle_done", done_a, 1'b0);
         chk("idle_br", br_a, 1'b0);
         chk("idle_busy", busy_a, 1'b0);
      end
      cmp_writes(0, "idle");

      // zero-word start goes straight to DONE
      start_a = 1'b1; wc_a = 9'd0;
      @(negedge clk);
      start_a = 1'b0;
      chk("zero_done", done_a, 1'b1);
      chk("zero_hold", hold_a, 1'b0);
      chk("zero_br", br_a, 1'b0);
      repeat (2) @(negedge clk);
      cmp_writes(0, "zero");

      // single-word reload from DONE
      bq = '{8'hFF, 8'h00, 8'h00, 8'h01};
      do_load(0, 1, 1'b0, 1000, cyc);
      chk("one_cycles", cyc, 32'd5);
      chk("one_done", done_a, 1'b1);
      ea = '{32'd0}; ed = '{32'h FF000001};
      cmp_writes(0, "one");

      // cycle-accurate two-word trace from DONE
      sel = 0;
      for (int i = 0; i < 12; i++) begin
         start_a = tbl[i].st; wc_a = tbl[i].wc;
         byte_valid = tbl[i].bv; byte_in = tbl[i].b;
         @(negedge clk);
         chk($sformatf("tbl%0d_br", i), br_a, tbl[i].br);
         chk($sformatf("tbl%0d_we", i), we_a, tbl[i].we);
         chk($sformatf("tbl%0d_addr", i), 32'(addr_a), 32'(tbl[i].addr));
         chk($sformatf("tbl%0d_hold", i), hold_a, tbl[i].hold);
         chk($sformatf("tbl%0d_busy", i), busy_a, tbl[i].busy);
         chk($sformatf("tbl%0d_done", i), done_a, tbl[i].done);
         if (tbl[i].we) chk($sformatf("tbl%0d_wdata", i), wd_a, tbl[i].wd);
      end
      start_a = 1'b0; byte_valid = 1'b0;
      ea = '{32'd0, 32'd1}; ed = '{32'h20080005, 32'h01095020};
      cmp_writes(0, "tbl");

      // same load with one stall cycle before each byte
      bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
      do_load(0, 2, 1'b1, 1000, cyc);
      chk("stall_cycles", cyc, 32'd18);
      ea = '{32'd0, 32'd1}; ed = '{32'h20080005, 32'h01095020};
      cmp_writes(0, "stall");

      // reset after 6 bytes of a 3-word load
      bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC};
      do_load(0, 3, 1'b0, 6, cyc);
      chk("mid_busy", busy_a, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_br", br_a, 1'b0);
      chk("arst_we", we_a, 1'b0);
      chk("arst_addr", 32'(addr_a), 32'd0);
      chk("arst_wdata", wd_a, 32'd0);
      chk("arst_hold", hold_a, 1'b1);
      chk("arst_busy", busy_a, 1'b0);
      chk("arst_done", done_a, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      ea = '{32'd0}; ed = '{32'h11223344};
      cmp_writes(0, "arst");
      bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(0, 1, 1'b0, 1000, cyc);
      chk("reload_cycles", cyc, 32'd5);
      ea = '{32'd0}; ed = '{32'hDEADBEEF};
      cmp_writes(0, "reload");
      cmp_writes(1, "b_quiet");

      // 2-bit address: count 5 clamps to 4, address wraps to 0 in DONE
      bq.delete();
      for (int i = 0; i < 16; i++) bq.push_back(8'(i));
      do_load(1, 5, 1'b0, 1000, cyc);
      chk("clamp_cycles", cyc, 32'd20);
      chk("clamp_done", m_done, 1'b1);
      chk("clamp_addr", m_addr, 32'd0);
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1'b1; byte_in = 8'h5A;
         @(negedge clk);
         chk("extra_br", m_br, 1'b0);
         chk("extra_done", m_done, 1'b1);
      end
      byte_valid = 1'b0;
      ea = '{32'd0, 32'd1, 32'd2, 32'd3};
      ed = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
      cmp_writes(1, "clamp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
